// File: rtl/pc_fetch_sequencer.sv
// Hack PC sequencer: fetch over req/ack, hold for execute, commit load or increment.
// Define PC_SEQ_BREAKPOINT_EN to add the single-address fetch breakpoint.
module pc_fetch_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic [WIDTH-1:0] pc_value,
  output logic             pc_reset,
  output logic             pc_load,
  output logic             pc_increment,
  output logic [WIDTH-1:0] pc_target,
  output logic             rom_req,
  output logic [WIDTH-1:0] rom_addr,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             jump_taken,
  input  logic [WIDTH-1:0] jump_addr,
  output logic             fault,
  output logic [WIDTH-1:0] retired
`ifdef PC_SEQ_BREAKPOINT_EN
  ,
  input  logic [WIDTH-1:0] bp_addr,
  input  logic             bp_enable,
  output logic             bp_hit
`endif
);

  // state   | meaning
  // IDLE    | stopped, waiting for run
  // FETCH   | rom_req held at pc_value until rom_ack or timeout
  // EXECUTE | instr held valid until exec_done
  // UPDATE  | one-cycle commit: pc_load on jump, else pc_increment
  // FAULT   | fetch timed out; left only through reset
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXECUTE,
    S_UPDATE,
    S_FAULT
  } state_t;

  localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [7:0] tcount;
  logic       jump_q;
  logic       bp_stop;

  assign pc_reset = reset;
  assign rom_addr = pc_value;

`ifdef PC_SEQ_BREAKPOINT_EN
  logic bp_skip;

  // Only the first FETCH cycle can match; bp_skip lets the resumed fetch through once.
  assign bp_stop = (state == S_FETCH) && (tcount == 8'd0) && bp_enable &&
                   (pc_value == bp_addr) && !bp_skip;

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_hit  <= 1'b0;
      bp_skip <= 1'b0;
    end else begin
      if (state == S_IDLE && run) bp_hit <= 1'b0;
      if (bp_stop) begin
        bp_hit  <= 1'b1;
        bp_skip <= 1'b1;
      end else if (state == S_FETCH && tcount == 8'd0) begin
        bp_skip <= 1'b0;
      end
    end
  end
`else
  assign bp_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    rom_req      = 1'b0;
    instr_valid  = 1'b0;
    pc_load      = 1'b0;
    pc_increment = 1'b0;
    fault        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (bp_stop) begin
          state_next = S_IDLE;
        end else begin
          rom_req = 1'b1;
          if (rom_ack)                            state_next = S_EXECUTE;
          else if (tcount + 8'd1 == TIMEOUT_TC)   state_next = S_FAULT;
        end
      end
      S_EXECUTE: begin
        instr_valid = 1'b1;
        if (exec_done) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        pc_load      = jump_q;
        pc_increment = !jump_q;
        state_next   = (halt_req || !run) ? S_IDLE : S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
    // Reset aborts whatever is in flight, so no strobe may escape in that cycle.
    if (reset) begin
      state_next   = S_IDLE;
      rom_req      = 1'b0;
      instr_valid  = 1'b0;
      pc_load      = 1'b0;
      pc_increment = 1'b0;
      fault        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr     <= '0;
      pc_target <= '0;
      jump_q    <= 1'b0;
      retired   <= '0;
      tcount    <= 8'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!bp_stop) begin
            if (rom_ack) begin
              instr  <= rom_data;
              tcount <= 8'd0;
            end else begin
              tcount <= tcount + 8'd1;
            end
          end
        end
        S_EXECUTE: begin
          if (exec_done) begin
            jump_q    <= jump_taken;
            pc_target <= jump_addr;
          end
        end
        S_UPDATE: retired <= retired + WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: PC/ROM/execute models plus a fetch-address scoreboard.
module tb_pc_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] pc_value;
  logic        pc_reset, pc_load, pc_increment;
  logic [15:0] pc_target;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_done, jump_taken;
  logic [15:0] jump_addr;
  logic        fault;
  logic [15:0] retired;
`ifdef PC_SEQ_BREAKPOINT_EN
  logic [15:0] bp_addr = 16'h0000;
  logic        bp_enable = 1'b0;
  logic        bp_hit;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch_sequencer #(.WIDTH(16), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
    .pc_value(pc_value), .pc_reset(pc_reset), .pc_load(pc_load),
    .pc_increment(pc_increment), .pc_target(pc_target),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .jump_taken(jump_taken), .jump_addr(jump_addr), .fault(fault), .retired(retired)
`ifdef PC_SEQ_BREAKPOINT_EN
    , .bp_addr(bp_addr), .bp_enable(bp_enable), .bp_hit(bp_hit)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // PC register driven by the sequencer strobes
  logic [15:0] pc_q;
  assign pc_value = pc_q;
  always @(posedge clk) begin
    if (pc_reset)          pc_q <= 16'h0000;
    else if (pc_load)      pc_q <= pc_target;
    else if (pc_increment) pc_q <= pc_q + 16'd1;
  end

  // ROM with programmable wait states
  int ack_delay = 0;
  int wait_cnt = 0;
  assign rom_data = rom_fn(rom_addr);
  assign rom_ack  = rom_req && (wait_cnt >= ack_delay);
  always @(posedge clk) begin
    if (rom_req && !rom_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // Execute stage
  logic        exec_en = 1'b1;
  logic        jump_en = 1'b0;
  logic [15:0] jump_at = 16'h0000;
  logic [15:0] jump_to = 16'h0000;
  assign exec_done  = instr_valid && exec_en;
  assign jump_taken = jump_en && (pc_q == jump_at);
  assign jump_addr  = jump_to;

  // Scoreboard: expected fetch addresses pushed by tests, popped on each accepted fetch
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_a;
  logic [15:0] exp_instr = 16'h0000;
  int          cyc = 0;
  int          last_commit_cyc = 0;
  int          gaps[$];
  int          load_cycles = 0;
  logic [15:0] last_load_target = 16'h0000;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rom_req && rom_ack) begin
      checks = checks + 1;
      if (exp_addr_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL fetch_unexpected rom_addr=%h", rom_addr);
      end else begin
        exp_a = exp_addr_q.pop_front();
        if (rom_addr !== exp_a) begin
          errors = errors + 1;
          $display("FAIL fetch_addr got=%h exp=%h", rom_addr, exp_a);
        end
        exp_instr = rom_fn(exp_a);
      end
    end
    if (instr_valid) begin
      checks = checks + 1;
      if (instr !== exp_instr) begin
        errors = errors + 1;
        $display("FAIL instr_latched got=%h exp=%h", instr, exp_instr);
      end
    end
    if (pc_load || pc_increment) begin
      checks = checks + 1;
      if (pc_load && pc_increment) begin
        errors = errors + 1;
        $display("FAIL strobe_exclusive load=%b inc=%b exp=not both", pc_load, pc_increment);
      end
      gaps.push_back(cyc - last_commit_cyc);
      last_commit_cyc = cyc;
      if (pc_load) begin
        load_cycles = load_cycles + 1;
        last_load_target = pc_target;
      end
    end
  end

  task automatic do_reset();
    run = 1'b0;
    halt_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs with run=1 and raises halt_req during the n-th commit; ends in IDLE.
  task automatic run_commits(input int n, input int budget, output bit ok);
    int c = 0;
    ok = 1'b0;
    run = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pc_load || pc_increment) begin
        c++;
        if (c == n) begin
          halt_req = 1'b1;
          ok = 1'b1;
          break;
        end
      end
    end
    @(negedge clk);
    halt_req = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_addr_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_drained left=%0d exp=0", name, exp_addr_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({pc_reset, rom_req, pc_load, pc_increment, fault, instr_valid} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_strobes got=%b exp=100000",
               {pc_reset, rom_req, pc_load, pc_increment, fault, instr_valid});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({retired, instr, pc_target, pc_q} !== 64'h0) begin
      errors++;
      $display("FAIL reset_values retired=%h instr=%h target=%h pc=%h exp=0",
               retired, instr, pc_target, pc_q);
    end
    checks++;
    if ({pc_reset, rom_req} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle pc_reset=%b rom_req=%b exp=00", pc_reset, rom_req);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    do_reset();
    for (int a = 0; a < 5; a++) exp_addr_q.push_back(16'(a));
    gaps.delete();
    run_commits(5, 60, ok);
    run = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL seq_timeout got=0 exp=1"); end
    checks++;
    if (retired !== 16'd5 || pc_q !== 16'd5) begin
      errors++;
      $display("FAIL seq_retired retired=%0d pc=%0d exp=5", retired, pc_q);
    end
    for (int g = 1; g < 5; g++) begin
      checks++;
      if (gaps.size() != 5 || gaps[g] != 3) begin
        errors++;
        $display("FAIL seq_gap idx=%0d got=%0d exp=3", g, (gaps.size() > g) ? gaps[g] : -1);
      end
    end
    check_drained("seq");
  endtask

  task automatic test_jump();
    bit ok;
    do_reset();
    jump_en = 1'b1; jump_at = 16'h0004; jump_to = 16'h0100;
    for (int a = 0; a < 5; a++) exp_addr_q.push_back(16'(a));
    exp_addr_q.push_back(16'h0100);
    load_cycles = 0;
    run_commits(6, 60, ok);
    run = 1'b0; jump_en = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL jump_timeout got=0 exp=1"); end
    checks++;
    if (load_cycles != 1 || last_load_target !== 16'h0100) begin
      errors++;
      $display("FAIL jump_load cycles=%0d target=%h exp=1/0100", load_cycles, last_load_target);
    end
    checks++;
    if (pc_q !== 16'h0101) begin errors++; $display("FAIL jump_pc got=%h exp=0101", pc_q); end
    check_drained("jump");
  endtask

  task automatic test_wait_states();
    int  req_cycles = 0;
    bit  got = 1'b0;
    do_reset();
    ack_delay = 3;
    exp_addr_q.push_back(16'h0000);
    run = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rom_req) req_cycles++;
      if (rom_req && rom_ack) begin got = 1'b1; break; end
    end
    halt_req = 1'b1;
    checks++;
    if (!got || req_cycles != 4) begin
      errors++;
      $display("FAIL wait_req_cycles got=%0d exp=4", req_cycles);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'hA5C3) begin
      errors++;
      $display("FAIL wait_instr valid=%b instr=%h exp=1/a5c3", instr_valid, instr);
    end
    repeat (2) @(negedge clk);
    halt_req = 1'b0; run = 1'b0;
    checks++;
    if (rom_req !== 1'b0 || retired !== 16'd1) begin
      errors++;
      $display("FAIL wait_commit rom_req=%b retired=%0d exp=0/1", rom_req, retired);
    end
    ack_delay = 0;
    check_drained("wait");
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    do_reset();
    ack_delay = 1000;
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fault) break;
      if (rom_req) req_cycles++;
    end
    run = 1'b0;
    checks++;
    if (fault !== 1'b1 || req_cycles != 15) begin
      errors++;
      $display("FAIL timeout_fault fault=%b fetch_cycles=%0d exp=1/15", fault, req_cycles);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fault !== 1'b1 || rom_req !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky fault=%b rom_req=%b exp=1/0", fault, rom_req);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got=%b exp=0", fault); end
    ack_delay = 0;
  endtask

  task automatic test_halt_resume();
    bit ok;
    bit got = 1'b0;
    do_reset();
    exp_addr_q.push_back(16'h0000);
    run_commits(1, 20, ok);
    checks++;
    if (ok !== 1'b1 || rom_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_idle ok=%b rom_req=%b exp=1/0", ok, rom_req);
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
    exp_addr_q.push_back(16'h0001);
    run_commits(1, 20, ok);
    run = 1'b0;
    checks++;
    if (ok !== 1'b1 || retired !== 16'd2 || pc_q !== 16'd2) begin
      errors++;
      $display("FAIL resume_next ok=%b retired=%0d pc=%0d exp=1/2/2", ok, retired, pc_q);
    end
    // run dropped during a long EXECUTE: instruction still commits, then IDLE
    exec_en = 1'b0;
    exp_addr_q.push_back(16'h0002);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_valid) begin got = 1'b1; break; end
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (!got || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL exec_wait instr_valid=%b exp=1", instr_valid);
    end
    exec_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pc_increment) begin got = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!got || rom_req !== 1'b0 || retired !== 16'd3) begin
      errors++;
      $display("FAIL run_low_commit got=%b rom_req=%b retired=%0d exp=1/0/3", got, rom_req, retired);
    end
    check_drained("halt");
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    jump_en = 1'b1; jump_at = 16'h0001; jump_to = 16'hFFFF;
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0001);
    exp_addr_q.push_back(16'hFFFF);
    exp_addr_q.push_back(16'h0000);
    run_commits(4, 40, ok);
    run = 1'b0; jump_en = 1'b0;
    checks++;
    if (ok !== 1'b1 || pc_q !== 16'h0001 || retired !== 16'd4) begin
      errors++;
      $display("FAIL wrap ok=%b pc=%h retired=%0d exp=1/0001/4", ok, pc_q, retired);
    end
    check_drained("wrap");
  endtask

  task automatic test_reset_in_execute();
    bit got = 1'b0;
    do_reset();
    exec_en = 1'b0;
    exp_addr_q.push_back(16'h0000);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_valid) begin got = 1'b1; break; end
    end
    run = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (!got || {pc_reset, pc_increment, pc_load, instr_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_exec_strobes got=%b exp=1000",
               {pc_reset, pc_increment, pc_load, instr_valid});
    end
    exec_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (retired !== 16'd0 || pc_q !== 16'd0 || rom_req !== 1'b0 || instr !== 16'd0) begin
      errors++;
      $display("FAIL reset_exec_abort retired=%0d pc=%h req=%b instr=%h exp=0",
               retired, pc_q, rom_req, instr);
    end
    check_drained("rst_exec");
  endtask

`ifdef PC_SEQ_BREAKPOINT_EN
  task automatic test_breakpoint();
    bit ok;
    bit got = 1'b0;
    do_reset();
    bp_addr = 16'h0002; bp_enable = 1'b1;
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0001);
    run = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bp_hit) begin got = 1'b1; break; end
    end
    run = 1'b0;
    checks++;
    if (!got || retired !== 16'd2 || rom_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_stop hit=%b retired=%0d rom_req=%b exp=1/2/0", bp_hit, retired, rom_req);
    end
    check_drained("bp_stop");
    repeat (2) @(negedge clk);
    exp_addr_q.push_back(16'h0002);
    run_commits(1, 20, ok);
    run = 1'b0;
    checks++;
    if (ok !== 1'b1 || bp_hit !== 1'b0 || retired !== 16'd3) begin
      errors++;
      $display("FAIL bp_resume ok=%b hit=%b retired=%0d exp=1/0/3", ok, bp_hit, retired);
    end
    bp_enable = 1'b0;
    check_drained("bp_resume");
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_wait_states();
    test_timeout();
    test_halt_resume();
    test_wrap();
    test_reset_in_execute();
`ifdef PC_SEQ_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Controller that drives the Hack program counter's reset, load and increment strobes.
- Sequences each instruction through fetch, execute and PC-update phases.
- Fetches from instruction ROM over a req/ack handshake, presents the latched instruction to the execute stage, then commits either a jump (load) or a fall-through (increment).
- Sits between the PC register, the instruction ROM and the CPU execute stage; owns all PC control.

Parameters:
- WIDTH, 16, address and instruction width.
- TIMEOUT, 15, maximum FETCH cycles without rom_ack before a fault; range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset; synchronous, active-high.
- run  input  1  level enable; sequencer leaves IDLE only while high.
- halt_req  input  1  stop after the current instruction commits.
- pc_value  input  WIDTH  current PC output.
- pc_reset  output  1  PC clear strobe.
- pc_load  output  1  PC load strobe.
- pc_increment  output  1  PC increment strobe.
- pc_target  output  WIDTH  PC load value.
- rom_req  output  1  fetch request.
- rom_addr  output  WIDTH  fetch address.
- rom_ack  input  1  fetch data valid.
- rom_data  input  WIDTH  fetched instruction.
- instr  output  WIDTH  latched instruction.
- instr_valid  output  1  instruction held for the execute stage.
- exec_done  input  1  execute stage finished.
- jump_taken  input  1  jump decision, valid with exec_done.
- jump_addr  input  WIDTH  jump target, valid with exec_done.
- fault  output  1  sticky fetch-timeout flag.
- retired  output  WIDTH  count of committed instructions.

Behaviour:
- Reset:
  - pc_reset is asserted combinationally whenever reset is high, so the PC clears on the same edge.
  - State goes to IDLE.
  - instr, pc_target, retired and the timeout counter go to 0.
  - fault goes to 0.
  - All other strobes are 0.
  - Reset mid-operation aborts any state immediately, with no commit.
- States: IDLE, FETCH, EXECUTE, UPDATE, FAULT.
- IDLE:
  - All strobes are low.
  - If run=1, go to FETCH on the next edge.
- FETCH:
  - rom_req=1 and rom_addr=pc_value.
  - On rom_ack=1 (acceptable in the first FETCH cycle): latch rom_data into instr, clear the timeout counter, go to EXECUTE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT with no ack, go to FAULT.
- EXECUTE:
  - instr_valid=1 and instr is stable.
  - On exec_done=1: latch jump_taken and jump_addr (into pc_target), go to UPDATE.
  - Wait indefinitely otherwise; no timeout applies.
- UPDATE (exactly one cycle):
  - pc_load = latched jump_taken.
  - pc_increment = NOT latched jump_taken.
  - pc_load and pc_increment are never both high.
  - retired increments and wraps 0xFFFF to 0x0000.
  - Next state is IDLE if halt_req=1 or run=0 (both sampled in UPDATE); otherwise FETCH.
  - The FETCH that follows sees the updated pc_value.
- FAULT:
  - fault=1 and all strobes low.
  - The only exit is reset.
- Latency: minimum 3 cycles per instruction (FETCH with immediate ack, EXECUTE with immediate done, UPDATE).
- PC wrap-around:
  - Increment at 0xFFFF yields 0x0000 in the PC. The sequencer takes no special action.
  - A jump to the current address is legal.
- run deasserted in FETCH or EXECUTE: the current instruction still completes and commits, then the sequencer goes to IDLE.
- halt_req outside UPDATE is ignored (level, not latched).
- rom_ack outside FETCH and exec_done outside EXECUTE are ignored.

Optional Feature:
- Macro: PC_SEQ_BREAKPOINT_EN.
- When defined, adds these ports:
  - bp_addr input WIDTH.
  - bp_enable input 1.
  - bp_hit output 1.
- Breakpoint behaviour when defined:
  - On entry to FETCH, if bp_enable=1 and pc_value==bp_addr, the sequencer goes to IDLE instead of requesting.
  - bp_hit is set (sticky) at that point.
  - bp_hit clears on reset or on the next IDLE-to-FETCH transition.
  - A breakpoint match suppresses itself for exactly one fetch after resume, so run can step past it.
- When not defined: no breakpoint ports or logic; behaviour is as above.

Test Plan:
- Reset, run=1, rom_ack and exec_done tied high, jump_taken=0, 5 instructions: pc_increment pulses every 3rd cycle; rom_addr 0,1,2,3,4; retired=5.
- Jump: at pc=0x0004, exec_done with jump_taken=1, jump_addr=0x0100 -> pc_load=1 for one cycle with pc_target=0x0100; pc_increment=0; next rom_addr=0x0100.
- ROM wait states: rom_ack delayed 3 cycles -> rom_req held 4 cycles, then instr=rom_data. With TIMEOUT=15 and no ack -> fault=1 after 15 FETCH cycles; reset clears it.
- halt_req=1 during UPDATE -> IDLE next cycle with no rom_req; run toggled low then high resumes at the next PC.
- Wrap/reset: pc_value=0xFFFF, fall-through -> next rom_addr=0x0000. Reset asserted in EXECUTE -> pc_reset=1 that cycle, no pc_increment, retired=0.
- PC_SEQ_BREAKPOINT_EN: bp_addr=0x0002, bp_enable=1 -> stop with bp_hit=1 and no fetch of 0x0002; run re-pulse fetches 0x0002.
